// File: rtl/sync_fifo_ctrl_if.sv
// Handshake bundle between the FIFO wrapper (master) and the pointer/flag controller (slave).
// With SYNC_FIFO_ERR_FLAG_EN defined, the bundle also carries the sticky overflow/underflow flags.
interface sync_fifo_ctrl_if #(
  parameter int DEPTH = 4
);
  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [DEPTH:0]   count;
  logic             ram_wr_en;
  logic [DEPTH-1:0] ram_wr_addr;
  logic [DEPTH-1:0] ram_rd_addr;
`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output push, pop, flush,
    input  full, empty, almost_full, almost_empty, count,
`ifdef SYNC_FIFO_ERR_FLAG_EN
    input  overflow, underflow,
`endif
    input  ram_wr_en, ram_wr_addr, ram_rd_addr
  );

  modport slave (
    input  push, pop, flush,
    output full, empty, almost_full, almost_empty, count,
`ifdef SYNC_FIFO_ERR_FLAG_EN
    output overflow, underflow,
`endif
    output ram_wr_en, ram_wr_addr, ram_rd_addr
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller turning a 1W1R ram into a first-word-fall-through synchronous FIFO.
// Define SYNC_FIFO_ERR_FLAG_EN to add the sticky overflow/underflow outputs.
module sync_fifo_ctrl #(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_ctrl_if.slave bus
);

  localparam logic [DEPTH:0] AF_CNT = (DEPTH+1)'(AF_LEVEL);
  localparam logic [DEPTH:0] AE_CNT = (DEPTH+1)'(AE_LEVEL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH:0] wr_ptr;
  logic [DEPTH:0] rd_ptr;
  logic [DEPTH:0] count_w;
  logic           full_w;
  logic           empty_w;
  logic           push_ok;
  logic           pop_ok;

  always_comb begin
    count_w = wr_ptr - rd_ptr;
    empty_w = (wr_ptr == rd_ptr);
    full_w  = (wr_ptr[DEPTH-1:0] == rd_ptr[DEPTH-1:0]) &&
              (wr_ptr[DEPTH] != rd_ptr[DEPTH]);
  end

  assign push_ok = bus.push & ~full_w  & ~bus.flush;
  assign pop_ok  = bus.pop  & ~empty_w & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Gating with rst_n keeps a push held through reset from reaching the ram.
  assign bus.ram_wr_en    = push_ok & rst_n;
  assign bus.ram_wr_addr  = wr_ptr[DEPTH-1:0];
  assign bus.ram_rd_addr  = rd_ptr[DEPTH-1:0];
  assign bus.count        = count_w;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_w >= AF_CNT);
  assign bus.almost_empty = (count_w <= AE_CNT);

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic overflow_r;
  logic underflow_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (bus.flush) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.push & full_w) overflow_r  <= 1'b1;
      if (bus.pop & empty_w) underflow_r <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
`endif

endmodule
